// File: rtl/dmem_pkg.sv
// Shared state encoding and sizing constants for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int DMEM_CNT_W           = 4;
    localparam int DMEM_DEFAULT_LATENCY = 2;
    localparam int DMEM_DEFAULT_DEPTH   = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: one clocked write port and one combinational read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = DMEM_DEFAULT_DEPTH,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; contents must survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: services one load/store after LATENCY cycles, stalling the pipeline meanwhile.
// Optional DMEM_ERR_EN adds the mem_err port and misaligned/out-of-range access checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DMEM_DEFAULT_DEPTH,
    parameter int LATENCY    = DMEM_DEFAULT_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           mem_access_addr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_en,
    input  logic                  mem_read_en,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_stall,
    output logic                  mem_done
`ifdef DMEM_ERR_EN
    ,
    output logic                  mem_err
`endif
);

    localparam int                    IDX_W  = $clog2(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);
    localparam logic [DMEM_CNT_W-1:0] CNT_1  = DMEM_CNT_W'(1);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  is_rd_q, is_rd_d;
    logic                  bad_q, bad_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req;
    logic                  in_bad;
    logic [IDX_W-1:0]      in_idx;
    logic                  in_idle;
    logic                  enter_resp;
    logic [IDX_W-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic                  cur_wr, cur_rd, cur_bad;
    logic                  arr_wr_en;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign req     = mem_read_en | mem_write_en;
    assign in_idx  = mem_access_addr[2 +: IDX_W];
    assign in_idle = (state_q == ST_IDLE);

`ifdef DMEM_ERR_EN
    assign in_bad = (mem_access_addr[1:0] != 2'b00) || (mem_access_addr[31:2+IDX_W] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_access_addr[1:0], mem_access_addr[31:2+IDX_W]};
    assign in_bad           = 1'b0;
`endif

    // A single-cycle access completes straight out of IDLE, before the holding registers load.
    assign cur_idx   = in_idle ? in_idx         : idx_q;
    assign cur_wdata = in_idle ? mem_write_data : wdata_q;
    assign cur_wr    = in_idle ? mem_write_en   : is_wr_q;
    assign cur_rd    = in_idle ? mem_read_en    : is_rd_q;
    assign cur_bad   = in_idle ? in_bad         : bad_q;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        is_rd_d    = is_rd_q;
        bad_d      = bad_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = in_idx;
                    wdata_d = mem_write_data;
                    is_wr_d = mem_write_en;
                    is_rd_d = mem_read_en;
                    bad_d   = in_bad;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_1;
                if (cnt_q == CNT_1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Store wins over load; a flagged access neither writes nor returns array data.
    always_comb begin
        done_d  = enter_resp;
        rdata_d = rdata_q;
        if (enter_resp && cur_rd && !cur_wr) begin
            rdata_d = cur_bad ? '0 : arr_rdata;
        end
    end

    // A reset landing on the commit edge must discard the pending store.
    assign arr_wr_en = reset && enter_resp && cur_wr && !cur_bad;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_idx  (cur_idx),
        .wr_data (cur_wdata),
        .rd_idx  (cur_idx),
        .rd_data (arr_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            is_rd_q <= 1'b0;
            bad_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            is_rd_q <= is_rd_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Address/data holding registers are qualified by state and need no reset.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

`ifdef DMEM_ERR_EN
    logic err_q, err_d;

    assign err_d = enter_resp && cur_bad;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`endif

    // Only the IDLE request path is combinational; it is gated so reset always drops the stall.
    assign mem_stall     = reset && ((in_idle && req) || (state_q == ST_WAIT));
    assign mem_done      = done_q;
    assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance against a word-array reference model.
module tb_dmem_responder;

    localparam int WORDS = 128;

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] wd;
        bit          w;
        bit          r;
    } op_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        we_a  = 1'b0;
    logic        re_a  = 1'b0;
    logic        we_b  = 1'b0;
    logic        re_b  = 1'b0;
    logic [31:0] rd_a, rd_b;
    logic        stall_a, stall_b, done_a, done_b;
`ifdef DMEM_ERR_EN
    logic        err_a, err_b;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [2][WORDS];
    logic [31:0] ref_rd  [2];
    int          lat     [2] = '{2, 1};

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .DEPTH(WORDS), .LATENCY(2)) dut_a (
        .clk             (clk),
        .reset           (reset),
        .mem_access_addr (addr),
        .mem_write_data  (wdata),
        .mem_write_en    (we_a),
        .mem_read_en     (re_a),
        .mem_read_data   (rd_a),
        .mem_stall       (stall_a),
        .mem_done        (done_a)
`ifdef DMEM_ERR_EN
        ,
        .mem_err         (err_a)
`endif
    );

    dmem_responder #(.DATA_WIDTH(32), .DEPTH(WORDS), .LATENCY(1)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .mem_access_addr (addr),
        .mem_write_data  (wdata),
        .mem_write_en    (we_b),
        .mem_read_en     (re_b),
        .mem_read_data   (rd_b),
        .mem_stall       (stall_b),
        .mem_done        (done_b)
`ifdef DMEM_ERR_EN
        ,
        .mem_err         (err_b)
`endif
    );

    // ---------------- reference model ----------------
    function automatic bit model_bad(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return (a % 4 != 0) || (a >= 4 * WORDS);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_access(input int sel, input logic [31:0] a, input logic [31:0] wd,
                                input bit w, input bit r, output bit bad);
        int idx;
        idx = int'((a / 4) % WORDS);
        bad = model_bad(a);
        if (w) begin
            if (!bad) ref_mem[sel][idx] = wd;
        end else if (r) begin
            ref_rd[sel] = bad ? 32'h0 : ref_mem[sel][idx];
        end
    endtask

    // Drives one request in the current IDLE cycle and records what the DUT did; returns one cycle after RESP.
    task automatic run_access(input int sel, input logic [31:0] a, input logic [31:0] wd,
                              input bit w, input bit r, output int stall_cycles,
                              output int done_at, output logic [31:0] rd, output logic err);
        addr  = a;
        wdata = wd;
        if (sel == 0) begin we_a = w; re_a = r; end
        else          begin we_b = w; re_b = r; end
        stall_cycles = 0;
        done_at      = -1;
        rd           = 'x;
        err          = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((sel == 0) ? stall_a : stall_b) stall_cycles++;
            if ((sel == 0) ? done_a : done_b) begin
                done_at = c;
                rd      = (sel == 0) ? rd_a : rd_b;
`ifdef DMEM_ERR_EN
                err     = (sel == 0) ? err_a : err_b;
`endif
                break;
            end
            @(posedge clk);
            #1;
            // enables stay up as the stalled pipeline would hold them; the bus contents must be ignored
            addr  = $urandom;
            wdata = $urandom;
        end
        @(posedge clk);
        #1;
        we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        addr  = 32'h10;
        we_a  = 1'b1;
        re_b  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL reset stall_a: got %b want 0", stall_a); end
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL reset stall_b: got %b want 0", stall_b); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset done_a: got %b want 0", done_a); end
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset rd_a: got %h want 0", rd_a); end
        checks++; if (rd_b !== 32'h0) begin errors++; $display("FAIL reset rd_b: got %h want 0", rd_b); end
`ifdef DMEM_ERR_EN
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset err_a: got %b want 0", err_a); end
`endif
        we_a = 1'b0; re_b = 1'b0; reset = 1'b1;
        ref_rd[0] = '0; ref_rd[1] = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ops(input string nm, input op_t ops[$]);
        int          st, dn;
        logic [31:0] rd;
        logic        er;
        bit          bad;
        foreach (ops[i]) begin
            run_access(ops[i].sel, ops[i].a, ops[i].wd, ops[i].w, ops[i].r, st, dn, rd, er);
            model_access(ops[i].sel, ops[i].a, ops[i].wd, ops[i].w, ops[i].r, bad);
            checks++;
            if (dn !== lat[ops[i].sel]) begin
                errors++; $display("FAIL %s[%0d] done cycle: got %0d want %0d", nm, i, dn, lat[ops[i].sel]);
            end
            checks++;
            if (st !== lat[ops[i].sel]) begin
                errors++; $display("FAIL %s[%0d] stall cycles: got %0d want %0d", nm, i, st, lat[ops[i].sel]);
            end
            checks++;
            if (rd !== ref_rd[ops[i].sel]) begin
                errors++; $display("FAIL %s[%0d] read data: got %h want %h", nm, i, rd, ref_rd[ops[i].sel]);
            end
`ifdef DMEM_ERR_EN
            checks++;
            if (er !== bad) begin
                errors++; $display("FAIL %s[%0d] mem_err: got %b want %b", nm, i, er, bad);
            end
`endif
        end
    endtask

    task automatic test_store_load();
        op_t ops[$];
        ops.push_back('{0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0});
        ops.push_back('{0, 32'h14, 32'h12345678, 1'b1, 1'b0});
        ops.push_back('{0, 32'h10, 32'h0,        1'b0, 1'b1});
        check_ops("store_load", ops);
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        ops.push_back('{0, 32'h10, 32'h0, 1'b0, 1'b1});
        ops.push_back('{0, 32'h14, 32'h0, 1'b0, 1'b1});
        check_ops("back_to_back", ops);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({stall_a, done_a} !== 2'b00) begin
                errors++; $display("FAIL back_to_back idle[%0d] stall/done: got %b want 00", i, {stall_a, done_a});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_latency1();
        op_t         ops[$];
        logic [31:0] v;
        v = $urandom;
        ops.push_back('{1, 32'h20, v,     1'b1, 1'b0});
        ops.push_back('{1, 32'h20, 32'h0, 1'b0, 1'b1});
        check_ops("latency1", ops);
    endtask

    task automatic test_reset_mid_access();
        op_t ops[$];
        ops.push_back('{0, 32'h30, 32'h0BADF00D, 1'b1, 1'b0});
        check_ops("mid_reset_preload", ops);
        addr  = 32'h30;
        wdata = 32'hA5A5A5A5;
        we_a  = 1'b1;
        @(negedge clk);
        checks++; if (stall_a !== 1'b1) begin errors++; $display("FAIL mid_reset request stall: got %b want 1", stall_a); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL mid_reset stall: got %b want 0", stall_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL mid_reset done: got %b want 0", done_a); end
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL mid_reset read data: got %h want 0", rd_a); end
        we_a  = 1'b0;
        reset = 1'b1;
        ref_rd[0] = '0; ref_rd[1] = '0;
        @(posedge clk);
        #1;
        ops.delete();
        ops.push_back('{0, 32'h30, 32'h0, 1'b0, 1'b1});
        check_ops("mid_reset_reload", ops);
    endtask

    task automatic test_wrap();
        op_t ops[$];
        ops.push_back('{0, 32'h000, 32'h0000CAFE, 1'b1, 1'b0});
        ops.push_back('{0, 32'h200, 32'h77777777, 1'b1, 1'b0});
        ops.push_back('{0, 32'h000, 32'h0,        1'b0, 1'b1});
        check_ops("wrap", ops);
    endtask

    task automatic test_both_enables();
        op_t ops[$];
        ops.push_back('{0, 32'h10, 32'h0,  1'b0, 1'b1});
        ops.push_back('{0, 32'h40, 32'h11, 1'b1, 1'b1});
        ops.push_back('{0, 32'h40, 32'h0,  1'b0, 1'b1});
        check_ops("both_enables", ops);
    endtask

    task automatic test_random();
        op_t         ops[$];
        op_t         op;
        int          k, gap;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) ops.push_back('{s, 32'(i * 4), $urandom, 1'b1, 1'b0});
        end
        check_ops("random_preload", ops);
        for (int n = 0; n < 40; n++) begin
            op.sel = int'($urandom_range(0, 1));
            op.a   = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) == 0) op.a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) op.a[31:9] = 23'($urandom_range(1, 1000));
            op.wd  = $urandom;
            k      = int'($urandom_range(0, 3));
            op.w   = (k >= 2);
            op.r   = (k != 2);
            ops.delete();
            ops.push_back(op);
            check_ops("random", ops);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if ({stall_a, done_a, stall_b, done_b} !== 4'b0000) begin
                    errors++; $display("FAIL random idle[%0d] stall/done: got %b want 0000", n, {stall_a, done_a, stall_b, done_b});
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_latency1();
        test_reset_mid_access();
        test_wrap();
        test_both_enables();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
